// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Purpose : Byte/half/word/dword load/store unit with valid/ready request side
//           and req/ack variable-latency memory side; one response per request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W/8-1:0]   o_mem_be,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_resp_valid,
  output logic [1:0]            o_resp_err,
  output logic [DATA_W-1:0]     o_resp_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0]     r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_resp_err;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_accept;
  logic              w_timeout;
  logic [2:0]        w_align_mask;
  logic              w_misal;
  logic              w_illegal;
  logic              w_bad;
  logic [1:0]        w_err_req;
  logic [OFF_W-1:0]  w_off;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_shifted;
  logic              w_sign;
  logic [DATA_W-1:0] w_ld;

  assign w_accept  = (r_state == S_IDLE) && i_req_valid;
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);
  assign w_off     = i_req_addr[OFF_W-1:0];

  // Illegal size outranks misalignment in the reported error code.
  always_comb begin
    w_align_mask = 3'b000;
    case (i_req_size)
      2'b01:   w_align_mask = 3'b001;
      2'b10:   w_align_mask = 3'b011;
      2'b11:   w_align_mask = 3'b111;
      default: w_align_mask = 3'b000;
    endcase
    w_misal   = |(i_req_addr[2:0] & w_align_mask);
    w_illegal = (i_req_size == 2'b11) && (DATA_W == 32);
    w_bad     = w_misal || w_illegal;
    w_err_req = w_illegal ? ERR_ILLEGAL : (w_misal ? ERR_MISALGN : ERR_OK);
  end

  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      w_be[i] = i_req_we ? ((i >= int'(w_off)) && (i < int'(w_off) + (1 << i_req_size))) : 1'b1;
      case (i_req_size)
        2'b00:   w_wdata[8*i +: 8] = i_req_wdata[7:0];
        2'b01:   w_wdata[8*i +: 8] = i_req_wdata[8*(i%2) +: 8];
        2'b10:   w_wdata[8*i +: 8] = i_req_wdata[8*(i%4) +: 8];
        default: w_wdata[8*i +: 8] = i_req_wdata[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    w_shifted = i_mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    if (r_unsigned) w_sign = 1'b0;
    w_ld = w_shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= (8 << r_size)) w_ld[i] = w_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid) w_state_nxt = w_bad ? S_RESP : S_WAIT;
      S_WAIT:  if (i_mem_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == S_IDLE);
    o_mem_req    = (r_state == S_WAIT);
    o_resp_valid = (r_state == S_RESP);
  end

  // Counter sits at zero outside WAIT so it is already cleared on entry.
  always_ff @(posedge clk) begin
    if (!reset || r_state != S_WAIT) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_resp_err  <= ERR_OK;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_off      <= w_off;
        if (w_bad) begin
          r_resp_err  <= w_err_req;
          r_resp_data <= '0;
        end else begin
          r_mem_we    <= i_req_we;
          r_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
        end
      end
      if (r_state == S_WAIT) begin
        if (i_mem_ack) begin
          r_resp_err  <= ERR_OK;
          r_resp_data <= r_mem_we ? '0 : w_ld;
        end else if (w_timeout) begin
          r_resp_err  <= ERR_TIMEOUT;
          r_resp_data <= '0;
        end
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_resp_err  = r_resp_err;
  assign o_resp_data = r_resp_data;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Scoreboard bench for load_store_unit (32-bit instance plus a
//           64-bit instance for the wide-bus lane cases).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, req_unsigned, req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_data;

  logic        v64, we64, uns64, rdy64, mreq64, mwe64, ack64, rv64;
  logic [1:0]  size64, err64;
  logic [31:0] addr64, maddr64;
  logic [63:0] wdata64, mwdata64, rdata64, rdat64;
  logic [7:0]  mbe64;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_resp_valid(resp_valid),
    .o_resp_err(resp_err), .o_resp_data(resp_data)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(16)) u_dut64 (
    .clk(clk), .reset(reset),
    .i_req_valid(v64), .o_req_ready(rdy64), .i_req_we(we64),
    .i_req_size(size64), .i_req_unsigned(uns64), .i_req_addr(addr64),
    .i_req_wdata(wdata64), .o_mem_req(mreq64), .o_mem_we(mwe64),
    .o_mem_addr(maddr64), .o_mem_be(mbe64), .o_mem_wdata(mwdata64),
    .i_mem_ack(ack64), .i_mem_rdata(rdata64), .o_resp_valid(rv64),
    .o_resp_err(err64), .o_resp_data(rdat64)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_resp  = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  // Transaction observations captured by run_txn for the calling test.
  logic        obs_mreq_first, obs_we, obs_stable, obs_resp_after;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  int          obs_req_cycles;

  always @(negedge clk) begin
    if (reset === 1'b1 && resp_valid === 1'b1) begin
      n_resp++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got err=%b data=%h, required no response", resp_err, resp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({resp_err, resp_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL resp: got err=%b data=%h, required err=%b data=%h",
                   resp_err, resp_data, mon_exp[33:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_dly, input logic [31:0] rdata);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=%b, required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    obs_mreq_first = mem_req; obs_we = mem_we; obs_addr = mem_addr;
    obs_be = mem_be; obs_wdata = mem_wdata;
    obs_req_cycles = 0; obs_stable = 1'b1;
    while (mem_req === 1'b1 && obs_req_cycles < 64) begin
      if ({mem_we, mem_addr, mem_be, mem_wdata} !== {obs_we, obs_addr, obs_be, obs_wdata})
        obs_stable = 1'b0;
      if (obs_req_cycles == ack_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
      @(negedge clk);
      mem_ack = 1'b0;
      obs_req_cycles++;
    end
    obs_resp_after = resp_valid;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, mem_req, mem_we, resp_valid, mem_addr, mem_be, mem_wdata, resp_data, resp_err}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b mreq=%b we=%b rv=%b addr=%h be=%h wd=%h rd=%h err=%b, required rdy=1 others 0",
               req_ready, mem_req, mem_we, resp_valid, mem_addr, mem_be, mem_wdata, resp_data, resp_err);
    end
    reset = 1'b1;
  endtask

  task automatic test_load_byte();
    exp_q.push_back({2'b00, 32'hFFFF_FF80});
    run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 1, 32'h80FF_1234);
    n_tests++;
    if ({obs_mreq_first, obs_we, obs_addr, obs_be} !== {1'b1, 1'b0, 32'h1000, 4'hF}) begin
      n_fail++;
      $display("FAIL lb_mem: got req=%b we=%b addr=%h be=%h, required req=1 we=0 addr=00001000 be=f",
               obs_mreq_first, obs_we, obs_addr, obs_be);
    end
    n_tests++;
    if (obs_req_cycles !== 2 || obs_resp_after !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_latency: got req_cycles=%0d resp=%b, required 2 and 1", obs_req_cycles, obs_resp_after);
    end
    exp_q.push_back({2'b00, 32'h0000_0080});
    run_txn(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 1, 32'h80FF_1234);
    @(negedge clk);
    n_tests++;
    if ({resp_valid, resp_err, resp_data} !== {1'b0, 2'b00, 32'h0000_0080}) begin
      n_fail++;
      $display("FAIL resp_hold: got rv=%b err=%b data=%h, required rv=0 err=00 data=00000080",
               resp_valid, resp_err, resp_data);
    end
  endtask

  task automatic test_store();
    exp_q.push_back({2'b00, 32'h0});
    run_txn(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF, 0, 32'hDEAD_DEAD);
    n_tests++;
    if ({obs_we, obs_addr, obs_be, obs_wdata, obs_stable} !== {1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL sh_mem: got we=%b addr=%h be=%b wd=%h stable=%b, required we=1 addr=00002000 be=1100 wd=beefbeef stable=1",
               obs_we, obs_addr, obs_be, obs_wdata, obs_stable);
    end
    exp_q.push_back({2'b00, 32'h0});
    run_txn(1'b1, 2'b00, 1'b0, 32'h2001, 32'h1234_5677, 3, 32'hDEAD_DEAD);
    n_tests++;
    if ({obs_be, obs_wdata, obs_stable, obs_req_cycles} !== {4'b0010, 32'h7777_7777, 1'b1, 4}) begin
      n_fail++;
      $display("FAIL sb_mem: got be=%b wd=%h stable=%b cycles=%0d, required be=0010 wd=77777777 stable=1 cycles=4",
               obs_be, obs_wdata, obs_stable, obs_req_cycles);
    end
  endtask

  task automatic test_errors();
    exp_q.push_back({2'b01, 32'h0});
    run_txn(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, 0, 32'hFFFF_FFFF);
    n_tests++;
    if ({obs_mreq_first, obs_resp_after} !== 2'b01) begin
      n_fail++;
      $display("FAIL misaligned_path: got mem_req=%b resp=%b, required 0 and 1", obs_mreq_first, obs_resp_after);
    end
    exp_q.push_back({2'b11, 32'h0});
    run_txn(1'b0, 2'b11, 1'b0, 32'h1001, 32'h0, 0, 32'hFFFF_FFFF);
    n_tests++;
    if ({obs_mreq_first, obs_resp_after} !== 2'b01) begin
      n_fail++;
      $display("FAIL illegal_path: got mem_req=%b resp=%b, required 0 and 1", obs_mreq_first, obs_resp_after);
    end
    exp_q.push_back({2'b01, 32'h0});
    run_txn(1'b1, 2'b01, 1'b0, 32'h1003, 32'hAAAA, 0, 32'h0);
  endtask

  task automatic test_timeout();
    logic bad;
    exp_q.push_back({2'b10, 32'h0});
    run_txn(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, -1, 32'h0);
    n_tests++;
    if (obs_req_cycles !== 16 || obs_resp_after !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got req_cycles=%0d resp=%b, required 16 and 1", obs_req_cycles, obs_resp_after);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL late_ack: got disturbance rdy=%b mreq=%b rv=%b, required idle", req_ready, mem_req, resp_valid);
    end
    exp_q.push_back({2'b00, 32'hCAFE_F00D});
    run_txn(1'b0, 2'b10, 1'b0, 32'h3004, 32'h0, 15, 32'hCAFE_F00D);
    n_tests++;
    if (obs_req_cycles !== 16) begin
      n_fail++;
      $display("FAIL ack_at_timeout: got req_cycles=%0d, required 16", obs_req_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int  guard;
    logic bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4000;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait: got mem_req=%b, required 1", mem_req);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_mid: got mreq=%b rdy=%b rv=%b, required 0 1 0", mem_req, req_ready, resp_valid);
    end
    reset = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_no_resp: got resp_valid=1, required 0");
    end
  endtask

  task automatic test_back_to_back();
    logic        t_we  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [1:0]  t_size[8] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
    logic        t_uns [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    logic [31:0] t_addr[8] = '{32'h100, 32'h101, 32'h103, 32'h102, 32'h102, 32'h100, 32'h107, 32'h100};
    logic [33:0] t_exp [8] = '{{2'b00, 32'hC3A5_7E81}, {2'b00, 32'h0000_007E}, {2'b00, 32'h0000_00C3},
                               {2'b00, 32'hFFFF_C3A5}, {2'b01, 32'h0}, {2'b00, 32'h0000_7E81},
                               {2'b00, 32'h0}, {2'b11, 32'h0}};
    logic bb_done;
    int   start;
    bb_done = 1'b0;
    start   = n_resp;
    fork
      begin
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          int g;
          req_valid = 1'b1; req_we = t_we[k]; req_size = t_size[k];
          req_unsigned = t_uns[k]; req_addr = t_addr[k]; req_wdata = 32'h55;
          exp_q.push_back(t_exp[k]);
          g = 0;
          while (req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
          @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        bb_done = 1'b1;
      end
      begin
        int g2;
        g2 = 0;
        while (!bb_done && g2 < 300) begin
          @(negedge clk);
          mem_ack = mem_req; mem_rdata = 32'hC3A5_7E81;
          g2++;
        end
        mem_ack = 1'b0;
      end
    join
    n_tests++;
    if ((n_resp - start) != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d responses, %0d pending, required 8 and 0", n_resp - start, exp_q.size());
    end
  endtask

  task automatic test_wide_bus();
    int g;
    @(negedge clk);
    v64 = 1'b1; we64 = 1'b0; size64 = 2'b01; uns64 = 1'b0; addr64 = 32'h6;
    g = 0;
    while (rdy64 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    @(negedge clk);
    v64 = 1'b0;
    n_tests++;
    if ({mreq64, maddr64, mbe64} !== {1'b1, 32'h0, 8'hFF}) begin
      n_fail++;
      $display("FAIL lh64_mem: got req=%b addr=%h be=%h, required 1 00000000 ff", mreq64, maddr64, mbe64);
    end
    ack64 = 1'b1; rdata64 = 64'h8001_0000_0000_0000;
    @(negedge clk);
    ack64 = 1'b0;
    n_tests++;
    if ({rv64, err64, rdat64} !== {1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_8001}) begin
      n_fail++;
      $display("FAIL lh64_resp: got rv=%b err=%b data=%h, required 1 00 ffffffffffff8001", rv64, err64, rdat64);
    end
    @(negedge clk);
    v64 = 1'b1; we64 = 1'b1; size64 = 2'b10; addr64 = 32'h4; wdata64 = 64'h0000_0000_DEAD_BEEF;
    g = 0;
    while (rdy64 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    @(negedge clk);
    v64 = 1'b0;
    n_tests++;
    if ({mwe64, mbe64, mwdata64} !== {1'b1, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF}) begin
      n_fail++;
      $display("FAIL sw64_mem: got we=%b be=%h wd=%h, required 1 f0 deadbeefdeadbeef", mwe64, mbe64, mwdata64);
    end
    ack64 = 1'b1;
    @(negedge clk);
    ack64 = 1'b0;
    n_tests++;
    if ({rv64, err64, rdat64} !== {1'b1, 2'b00, 64'h0}) begin
      n_fail++;
      $display("FAIL sw64_resp: got rv=%b err=%b data=%h, required 1 00 0", rv64, err64, rdat64);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    v64 = 1'b0; we64 = 1'b0; size64 = 2'b00; uns64 = 1'b0; addr64 = 32'h0;
    wdata64 = 64'h0; ack64 = 1'b0; rdata64 = 64'h0;
    test_reset();
    test_load_byte();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_wide_bus();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
